// File: rtl/seq_match_display.sv
// seq_match_display: serial pattern detector feeding a BCD match counter that is
// scanned across eight multiplexed seven-segment digits (two four-digit banks).
// Pipeline: p0 = detector history/fill, p1 = BCD count, registered display outputs.
// Build option: define SEQ_MATCH_OVERLAP_EN for overlapping detection; left
// undefined, the history restarts after every match.
module seq_match_display #(
  parameter int                 PAT_LEN  = 4,
  parameter logic [PAT_LEN-1:0] PATTERN  = 4'b1101,
  parameter int                 DIGITS   = 8,
  parameter int                 SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic       s_valid,
  input  logic       clr,
  output logic       match,
  output logic [6:0] a_to_g0,
  output logic [6:0] a_to_g1,
  output logic [7:0] an
);

  localparam int FILL_W = $clog2(PAT_LEN + 1);
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [2:0]        IDX_LAST  = 3'(DIGITS - 1);

  typedef enum logic [1:0] {ST_FILL, ST_ARMED, ST_HIT} state_t;

  state_t              state, state_nx;
  logic [PAT_LEN-1:0]  hist_p0, hist_sh, hist_nx;
  logic [FILL_W-1:0]   fill_p0, fill_sh, fill_nx;
  logic                complete;
  logic [7:0][3:0]     cnt_p1, cnt_nx;
  logic                carry;
  logic [7:0]          lead;
  logic                lead_acc;
  logic [DIV_W-1:0]    div;
  logic [2:0]          idx, idx_nx;
  logic [6:0]          seg_nx;

  // Accepted-bit count saturates once the history window is full.
  function automatic logic [FILL_W-1:0] sat_fill(input logic [FILL_W-1:0] f);
    return (f == FILL_FULL) ? f : f + 1'b1;
  endfunction

  // Active-high segments, [6]=a .. [0]=g; non-BCD codes stay dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h7E;
      4'd1:    return 7'h30;
      4'd2:    return 7'h6D;
      4'd3:    return 7'h79;
      4'd4:    return 7'h33;
      4'd5:    return 7'h5B;
      4'd6:    return 7'h5F;
      4'd7:    return 7'h70;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  // ---- p0: detector history, completion test and FSM next state ----
  // Clear wins over a simultaneous valid bit, which is then dropped.
  always_comb begin
    hist_sh  = {hist_p0[PAT_LEN-2:0], s};
    fill_sh  = sat_fill(fill_p0);
    complete = s_valid && !clr && (hist_sh == PATTERN) && (fill_sh == FILL_FULL);
    hist_nx  = hist_p0;
    fill_nx  = fill_p0;
    if (clr) begin
      hist_nx = '0;
      fill_nx = '0;
    end else if (s_valid) begin
`ifdef SEQ_MATCH_OVERLAP_EN
      hist_nx = hist_sh;
      fill_nx = fill_sh;
`else
      if (complete) begin
        hist_nx = '0;
        fill_nx = '0;
      end else begin
        hist_nx = hist_sh;
        fill_nx = fill_sh;
      end
`endif
    end
    state_nx = (fill_nx == FILL_FULL) ? ST_ARMED : ST_FILL;
    if (complete) state_nx = ST_HIT;
    match = (state == ST_HIT);
  end

  // Detector state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_FILL;
      hist_p0 <= '0;
      fill_p0 <= '0;
    end else begin
      state   <= state_nx;
      hist_p0 <= hist_nx;
      fill_p0 <= fill_nx;
    end
  end

  // ---- p1: BCD counter, carry ripples through all digits in one cycle ----
  // Nibbles at or above DIGITS never change, so the all-nines case wraps to zero.
  always_comb begin
    cnt_nx = cnt_p1;
    carry  = complete;
    for (int k = 0; k < 8; k++) begin
      if (k < DIGITS && carry) begin
        if (cnt_p1[k] == 4'd9) begin
          cnt_nx[k] = 4'd0;
        end else begin
          cnt_nx[k] = cnt_p1[k] + 4'd1;
          carry     = 1'b0;
        end
      end
    end
    if (clr) cnt_nx = '0;
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_p1 <= '0;
    else        cnt_p1 <= cnt_nx;
  end

  // ---- display: scan index and leading-zero blanking from the p1 count ----
  // lead[k] is set when nibble k or any higher nibble is nonzero.
  always_comb begin
    lead     = '0;
    lead_acc = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      lead_acc = lead_acc | (cnt_p1[k] != 4'd0);
      lead[k]  = lead_acc;
    end
    idx_nx = idx;
    if (div == DIV_LAST) idx_nx = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    seg_nx = (idx_nx == 3'd0 || lead[idx_nx]) ? seg_decode(cnt_p1[idx_nx]) : 7'h00;
  end

  // Scan divider and registered digit enables/segments, all switching together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div     <= '0;
      idx     <= '0;
      an      <= 8'h01;
      a_to_g0 <= 7'h7E;
      a_to_g1 <= 7'h00;
    end else begin
      div     <= (div == DIV_LAST) ? '0 : div + 1'b1;
      idx     <= idx_nx;
      an      <= 8'b1 << idx_nx;
      a_to_g0 <= idx_nx[2] ? 7'h00 : seg_nx;
      a_to_g1 <= idx_nx[2] ? seg_nx : 7'h00;
    end
  end

endmodule

// File: doc/seq_match_display.md
# seq_match_display

Parametrised serial pattern detector with a BCD match counter and a multiplexed eight-position seven-segment driver. It samples a qualified serial bit stream `s`, detects a configurable `PAT_LEN`-bit pattern, counts matches in BCD, and scans the count across two four-digit segment banks (`a_to_g0` for `an[3:0]`, `a_to_g1` for `an[7:4]`). It is the board-level top for the FSM lab and generalises the fixed single-pattern FSM top in pattern, length, digit count and scan rate.

## Interface
- `PAT_LEN`, 4: pattern length in bits, 2..16.
- `PATTERN`, 4'b1101: target pattern; MSB is the oldest bit received.
- `DIGITS`, 8: active display digits, 1..8; `an` bits at or above `DIGITS` stay 0.
- `SCAN_DIV`, 100000: clocks per digit slot, at least 2.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `s` in 1: serial data bit.
- `s_valid` in 1: `s` is sampled on rising `clk` when this is 1.
- `clr` in 1: synchronous clear of the counter and history.
- `match` out 1: one-cycle pulse on each detected pattern.
- `a_to_g0` out 7: segments for digits 0..3, active-high, `[6]`=a … `[0]`=g.
- `a_to_g1` out 7: segments for digits 4..7, same encoding.
- `an` out 8: digit enables, one-hot, active-high; bit k selects digit k.

## Operation
- **Detector history**
  - `hist[PAT_LEN-1:0]` shifts left on each `s_valid`, inserting `s` at bit 0.
  - `fill` counts accepted bits and saturates at `PAT_LEN`.
- **Detector states**
  - FILL: `fill<PAT_LEN`.
  - ARMED: `fill==PAT_LEN`, no match.
  - HIT: one cycle after a completing bit.
  - A completing bit is an `s_valid` cycle where the post-shift history equals `PATTERN` and the post-shift `fill==PAT_LEN`.
  - HIT returns to ARMED or FILL on the next clock, or stays in HIT when the next cycle also completes.
- **Match response**
  - On a completing bit, `match` is 1 in the following cycle.
  - On that same edge, the BCD counter increments by 1.
- **BCD counter**
  - `DIGITS` nibbles, each 0..9.
  - Increment ripples the carry through all nibbles in a single cycle.
  - At 10^DIGITS−1 it wraps to all-zero; no overflow flag.
- **Clear**
  - `clr`=1 zeroes the counter, `hist` and `fill`, and forces `match`=0 next cycle.
  - `clr` has priority over a simultaneous `s_valid`; that bit is discarded.
- **Scan**
  - `div` counts 0..`SCAN_DIV`−1. At terminal count, `idx` advances and wraps from `DIGITS`−1 to 0.
  - `an` = one-hot(`idx`).
  - `a_to_g0` = decode(nibble[`idx`]) when `idx`<4, else 0.
  - `a_to_g1` = decode(nibble[`idx`]) when `idx`≥4, else 0.
- **Leading-zero blanking**
  - A digit k>0 is blanked (segments 0, `an` still driven) when nibble k and all higher nibbles are 0.
  - Digit 0 always shows a digit.
- **Decode**
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B (hex).

## Timing
- **Reset values**
  - `match`=0, `an`=8'h01, `a_to_g0`=7'h7E, `a_to_g1`=7'h00.
  - `hist`=0, `fill`=0, `div`=0, `idx`=0, counter=0.
- **Latency**
  - `s_valid` edge to `match` and counter update: 1 cycle.
  - Counter change to segment outputs: 1 further cycle. All outputs are registered.
- **Scan period**
  - `an` advances every `SCAN_DIV` clocks; one full frame is `DIGITS`×`SCAN_DIV` clocks.
  - Segment data and `an` change on the same edge; no ghosting gap is required.
- **Reset mid-operation**
  - `reset` low forces all reset values immediately, independent of `clk`.
  - The first `s` accepted after release starts in FILL.
- **`s_valid` rate**
  - May be asserted every cycle, which allows back-to-back matches.

## Configuration
- `SEQ_MATCH_OVERLAP_EN` defined: overlapping detection.
  - After a match, `hist` and `fill` are retained.
  - For 1101, input 1101101 produces 2 matches.
- Undefined: non-overlapping detection.
  - After a match, `fill` resets to 0 and the history restarts.
  - For 1101, input 1101101 produces 1 match.

## Test plan
- **Reset values:** Release `reset`, then hold `s_valid`=0 for 20 cycles → `match`=0, `an`=01, `a_to_g0`=7E, `a_to_g1`=00 throughout.
- **Single match:** `SCAN_DIV`=4, `DIGITS`=8; send 1,1,0,1 with `s_valid` every cycle → `match` pulses once, 1 cycle after the last bit; digit 0 shows 30; digits 1..7 are blanked.
- **Overlap mode:** Send 1101101.
  - With `SEQ_MATCH_OVERLAP_EN`: 2 `match` pulses, count 2 (digit 0 = 6D).
  - Without it: 1 pulse, count 1.
- **Gapped input and BCD carry:** Apply 10 matches with random `s_valid` gaps → count 10; digit 1 = 30 and digit 0 = 7E, with digit 1 shown on `a_to_g0` when `an`=02.
- **Wrap and bank split:** `DIGITS`=5, count preloaded via matches to 99999, then one more match → all nibbles 0; only digit 0 is lit; `an` never sets bits 5..7; digit 4 appears on `a_to_g1`.
- **Clear and reset priority:**
  - Assert `clr` on the same cycle as a completing bit → no `match`, count 0.
  - Assert `reset` low mid-frame → outputs return to reset values immediately.
